usb_rx_phy: RTL and testbench
=============================

// Module: usb_rx_phy
// PURPOSE
//  Full-speed (12 Mb/s) USB receive front end: samples raw D+/D- at 4x oversampling on clk48, recovers bit phase,
//  NRZI-decodes, removes stuffed bits, detects SYNC and EOP, and delivers LSB-first bytes with framing/error strobes.
//  Feeds the packet layer (PID/token decode) downstream; also reports bus reset (long SE0) to the device state logic.
// PARAMETERS
//  RESET_CYCLES  120  consecutive clk48 cycles of SE0 (synchronized) before usb_reset asserts (2.5 us)
//  IDLE_BITS     8    consecutive J bit-samples required in WAIT_IDLE before accepting a new SYNC
// PORTS
//  clk48       in   1  48 MHz clock; all logic on posedge
//  rst         in   1  synchronous reset, active high
//  usb_d_p     in   1  raw D+ (asynchronous)
//  usb_d_n     in   1  raw D- (asynchronous)
//  line_state  out  2  synchronized {d_p,d_n}: 10=J, 01=K, 00=SE0, 11=SE1
//  rx_active   out  1  high from end of SYNC until EOP or error
//  rx_sop      out  1  1-cycle pulse when SYNC accepted
//  rx_data     out  8  assembled byte, bit 0 = first bit received; held until next byte
//  rx_valid    out  1  1-cycle pulse, rx_data valid
//  rx_eop      out  1  1-cycle pulse, clean EOP on byte boundary
//  rx_err      out  1  1-cycle pulse: stuff error, misaligned EOP, SE1, or bad SYNC
//  usb_reset   out  1  level, high while SE0 held >= RESET_CYCLES
// BEHAVIOUR
//  Reset: all outputs 0 (line_state 00), state WAIT_IDLE, phase 0, all counters 0.
//  Input: 2-flop synchronizer on d_p/d_n; line_state = 2nd stage. Everything below uses line_state.
//  Phase recovery: 2-bit phase counter; cleared to 0 on any line_state change between J and K, else increments mod 4.
//   Bit sample taken when phase==2 (mid-bit). Tolerates bit periods of 3..5 cycles since each edge re-centres.
//  NRZI: decoded bit = 1 if sample equals previous sample, 0 if it differs. previous sample := J on entering IDLE.
//  Bit unstuff: ones counter increments on decoded 1, clears on 0; after six 1s the next bit must be 0 and is
//   dropped (not shifted, not counted); a 1 there -> stuff error. Counter clears at SYNC accept.
//  States:
//   WAIT_IDLE: count consecutive J samples; at IDLE_BITS -> IDLE. Any non-J sample clears the count.
//   IDLE: first K on line_state (edge, phase cleared) -> SYNC, zero count 0. SE0/J keep IDLE.
//   SYNC: per sample: decoded 0 -> zero count+1; decoded 1 with zero count >=5 -> rx_sop, rx_active=1, DATA;
//    decoded 1 with count <5, SE0 or SE1 sample -> rx_err, WAIT_IDLE.
//   DATA: decoded non-stuff bits shift into byte register right-shift (new bit enters bit 7); bit counter 0..7;
//    on 8th bit rx_data <= byte, rx_valid pulses next cycle, counter wraps to 0.
//    SE0 sample: bit counter==0 -> rx_eop pulse, rx_active 0, EOP; else rx_err, rx_active 0, WAIT_IDLE.
//    Stuff error or SE1 sample -> rx_err, rx_active 0, WAIT_IDLE. No rx_eop for errored packets.
//   EOP: J sample -> IDLE; K or SE1 sample -> rx_err, WAIT_IDLE; SE0 stays.
//  Latency: raw pin edge to line_state 2 cycles; 8th-bit sample to rx_valid 1 cycle; SE0 sample to rx_eop 1 cycle.
//  Reset detect: independent 8-bit saturating counter, increments while line_state==SE0, clears otherwise;
//   usb_reset = (count >= RESET_CYCLES), drops the cycle after line_state leaves SE0. Does not alter FSM except
//   forcing WAIT_IDLE while high (rx_active cleared; rx_err not pulsed).
//  Simultaneous: rx_valid and rx_eop never coincide (byte strobe precedes SE0 sample by >=1 bit). rx_err and
//   rx_eop are mutually exclusive. rst dominates everything; mid-packet rst -> WAIT_IDLE so the packet tail is ignored.
// TESTING
//  1. SE0 held 200 cycles then J -> usb_reset rises cycle 122 after SE0 on pins, falls 3 cycles after J; no rx_* strobes.
//  2. 8 J bits, SYNC KJKJKJKK, bytes 0x2D,0x00,0x10, SE0 2 bits, J -> rx_sop, rx_valid x3 with 0x2D,0x00,0x10, rx_eop, rx_err never.
//  3. SYNC + bytes 0xFF,0xFF with stuffed 0 after every six 1s + EOP -> rx_valid 0xFF,0xFF, rx_eop; omit first stuff bit -> rx_err, no rx_eop.
//  4. SYNC + 12 data bits + EOP -> one rx_valid, then rx_err, rx_active low, no rx_eop; next clean packet after 8 J bits decodes.
//  5. Transmitter bit periods cycling 4,4,4,5 (and 4,4,4,3) clk48 for test 2 packet -> identical bytes, no error.
//  6. rst asserted 1 cycle mid-byte of test 2 packet -> all outputs 0 next cycle; remaining bits ignored; following packet decodes.

Source files
------------

// File: rtl/usb_rx_phy_if.sv
// rtl/usb_rx_phy_if.sv - raw USB pins in, synchronized line state and receive strobes out
interface usb_rx_phy_if;
    logic       usb_d_p;
    logic       usb_d_n;
    logic [1:0] line_state;
    logic       rx_active;
    logic       rx_sop;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_eop;
    logic       rx_err;
    logic       usb_reset;

    modport master (
        input  usb_d_p, usb_d_n,
        output line_state, rx_active, rx_sop, rx_data, rx_valid, rx_eop, rx_err, usb_reset
    );

    modport slave (
        output usb_d_p, usb_d_n,
        input  line_state, rx_active, rx_sop, rx_data, rx_valid, rx_eop, rx_err, usb_reset
    );
endinterface

// File: rtl/usb_rx_phy.sv
// rtl/usb_rx_phy.sv - full-speed USB receive front end: 4x oversampled bit recovery,
// NRZI decode, bit unstuffing, SYNC/EOP framing and bus-reset detection
module usb_rx_phy #(
    parameter int RESET_CYCLES = 120,
    parameter int IDLE_BITS    = 8
) (
    input  logic         clk48,
    input  logic         rst,
    usb_rx_phy_if.master usb
);
    localparam logic [1:0] LS_SE0 = 2'b00;
    localparam logic [1:0] LS_K   = 2'b01;
    localparam logic [1:0] LS_J   = 2'b10;
    localparam logic [1:0] LS_SE1 = 2'b11;
    localparam int         IDLE_W = $clog2(IDLE_BITS + 1);
    localparam logic [7:0] RESET_THRESH = 8'(RESET_CYCLES);

    typedef enum logic [2:0] {
        S_WAIT_IDLE,
        S_IDLE,
        S_SYNC,
        S_DATA,
        S_EOP
    } state_t;

    logic [1:0]        sync1_q;
    logic [1:0]        line_state_q;
    logic [1:0]        phase_q;
    logic [1:0]        phase_d;
    logic [7:0]        rst_cnt_q;
    logic [7:0]        rst_cnt_d;
    logic              usb_reset_q;
    state_t            state_q;
    logic [IDLE_W-1:0] idle_cnt_q;
    logic [1:0]        prev_q;
    logic [2:0]        zero_cnt_q;
    logic [2:0]        ones_q;
    logic [2:0]        bit_cnt_q;
    logic [7:0]        shift_q;
    logic [7:0]        shift_d;
    logic [7:0]        rx_data_q;
    logic              rx_active_q;
    logic              rx_sop_q;
    logic              rx_valid_q;
    logic              rx_eop_q;
    logic              rx_err_q;

    logic jk_edge;
    logic sample_en;
    logic is_jk;
    logic bit_val;

    // The edge is seen one stage early (sync1 vs line_state) so phase 0 is the
    // first cycle the new level is visible and phase 2 lands near mid-bit.
    always_comb begin
        jk_edge   = ((sync1_q == LS_J) && (line_state_q == LS_K)) ||
                    ((sync1_q == LS_K) && (line_state_q == LS_J));
        phase_d   = jk_edge ? 2'd0 : phase_q + 2'd1;
        sample_en = (phase_q == 2'd2);
        is_jk     = (line_state_q == LS_J) || (line_state_q == LS_K);
        bit_val   = (line_state_q == prev_q);
        shift_d   = {bit_val, shift_q[7:1]};
        if (line_state_q != LS_SE0) begin
            rst_cnt_d = 8'd0;
        end else if (rst_cnt_q == 8'hFF) begin
            rst_cnt_d = rst_cnt_q;
        end else begin
            rst_cnt_d = rst_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk48) begin
        if (rst) begin
            sync1_q      <= LS_SE0;
            line_state_q <= LS_SE0;
            phase_q      <= 2'd0;
            rst_cnt_q    <= 8'd0;
            usb_reset_q  <= 1'b0;
            state_q      <= S_WAIT_IDLE;
            idle_cnt_q   <= '0;
            prev_q       <= LS_J;
            zero_cnt_q   <= 3'd0;
            ones_q       <= 3'd0;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'd0;
            rx_data_q    <= 8'd0;
            rx_active_q  <= 1'b0;
            rx_sop_q     <= 1'b0;
            rx_valid_q   <= 1'b0;
            rx_eop_q     <= 1'b0;
            rx_err_q     <= 1'b0;
        end else begin
            sync1_q      <= {usb.usb_d_p, usb.usb_d_n};
            line_state_q <= sync1_q;
            phase_q      <= phase_d;
            rst_cnt_q    <= rst_cnt_d;
            usb_reset_q  <= (rst_cnt_d >= RESET_THRESH);
            rx_sop_q     <= 1'b0;
            rx_valid_q   <= 1'b0;
            rx_eop_q     <= 1'b0;
            rx_err_q     <= 1'b0;

            // A bus reset silently abandons whatever was in flight.
            if (usb_reset_q) begin
                state_q     <= S_WAIT_IDLE;
                rx_active_q <= 1'b0;
                idle_cnt_q  <= '0;
            end else begin
                case (state_q)
                    S_WAIT_IDLE: begin
                        if (sample_en) begin
                            if (line_state_q == LS_J) begin
                                if (idle_cnt_q == IDLE_W'(IDLE_BITS - 1)) begin
                                    state_q    <= S_IDLE;
                                    idle_cnt_q <= '0;
                                    prev_q     <= LS_J;
                                end else begin
                                    idle_cnt_q <= idle_cnt_q + IDLE_W'(1);
                                end
                            end else begin
                                idle_cnt_q <= '0;
                            end
                        end
                    end
                    S_IDLE: begin
                        if (line_state_q == LS_K) begin
                            state_q    <= S_SYNC;
                            zero_cnt_q <= 3'd0;
                        end
                    end
                    S_SYNC: begin
                        if (sample_en) begin
                            if (!is_jk) begin
                                rx_err_q <= 1'b1;
                                state_q  <= S_WAIT_IDLE;
                            end else begin
                                prev_q <= line_state_q;
                                if (!bit_val) begin
                                    if (zero_cnt_q != 3'd7) begin
                                        zero_cnt_q <= zero_cnt_q + 3'd1;
                                    end
                                end else if (zero_cnt_q >= 3'd5) begin
                                    rx_sop_q    <= 1'b1;
                                    rx_active_q <= 1'b1;
                                    ones_q      <= 3'd0;
                                    bit_cnt_q   <= 3'd0;
                                    state_q     <= S_DATA;
                                end else begin
                                    rx_err_q <= 1'b1;
                                    state_q  <= S_WAIT_IDLE;
                                end
                            end
                        end
                    end
                    S_DATA: begin
                        if (sample_en) begin
                            if (line_state_q == LS_SE0) begin
                                rx_active_q <= 1'b0;
                                if (bit_cnt_q == 3'd0) begin
                                    rx_eop_q <= 1'b1;
                                    state_q  <= S_EOP;
                                end else begin
                                    rx_err_q <= 1'b1;
                                    state_q  <= S_WAIT_IDLE;
                                end
                            end else if (line_state_q == LS_SE1) begin
                                rx_active_q <= 1'b0;
                                rx_err_q    <= 1'b1;
                                state_q     <= S_WAIT_IDLE;
                            end else begin
                                prev_q <= line_state_q;
                                if (ones_q == 3'd6) begin
                                    // Stuffed bit: must be a 0, never enters the byte.
                                    if (bit_val) begin
                                        rx_active_q <= 1'b0;
                                        rx_err_q    <= 1'b1;
                                        state_q     <= S_WAIT_IDLE;
                                    end else begin
                                        ones_q <= 3'd0;
                                    end
                                end else begin
                                    ones_q    <= bit_val ? ones_q + 3'd1 : 3'd0;
                                    shift_q   <= shift_d;
                                    bit_cnt_q <= bit_cnt_q + 3'd1;
                                    if (bit_cnt_q == 3'd7) begin
                                        rx_data_q  <= shift_d;
                                        rx_valid_q <= 1'b1;
                                    end
                                end
                            end
                        end
                    end
                    S_EOP: begin
                        if (sample_en) begin
                            if (line_state_q == LS_J) begin
                                state_q <= S_IDLE;
                                prev_q  <= LS_J;
                            end else if (line_state_q != LS_SE0) begin
                                rx_err_q <= 1'b1;
                                state_q  <= S_WAIT_IDLE;
                            end
                        end
                    end
                    default: begin
                        state_q <= S_WAIT_IDLE;
                    end
                endcase
            end
        end
    end

    assign usb.line_state = line_state_q;
    assign usb.rx_active  = rx_active_q;
    assign usb.rx_sop     = rx_sop_q;
    assign usb.rx_data    = rx_data_q;
    assign usb.rx_valid   = rx_valid_q;
    assign usb.rx_eop     = rx_eop_q;
    assign usb.rx_err     = rx_err_q;
    assign usb.usb_reset  = usb_reset_q;
endmodule

// File: tb/tb_usb_rx_phy.sv
// tb/tb_usb_rx_phy.sv - directed, table-driven bench for usb_rx_phy with an NRZI/bit-stuffing transmitter
module tb_usb_rx_phy;
    localparam logic [1:0] J   = 2'b10;
    localparam logic [1:0] K   = 2'b01;
    localparam logic [1:0] SE0 = 2'b00;

    typedef struct {
        logic [7:0]  sync;
        logic [31:0] data;
        int          nbits;
        int          omit;
        int          mode;
        int          exp_sop;
        int          exp_nvalid;
        logic [31:0] exp_bytes;
        int          exp_eop;
        int          exp_err;
    } vec_t;

    logic clk48 = 1'b0;
    logic rst;
    usb_rx_phy_if bus();

    usb_rx_phy #(.RESET_CYCLES(120), .IDLE_BITS(8)) dut (
        .clk48 (clk48),
        .rst   (rst),
        .usb   (bus)
    );

    always #10 clk48 = ~clk48;

    int n_checks = 0;
    int n_fail   = 0;
    int n_sop    = 0;
    int n_valid  = 0;
    int n_eop    = 0;
    int n_err    = 0;
    int n_act    = 0;
    int overlap_seen = 0;
    int valid_at_rst = 0;
    logic [7:0] got [0:255];
    vec_t vecs [8];

    always begin
        @(posedge clk48);
        #2;
        if (bus.rx_sop) n_sop++;
        if (bus.rx_eop) n_eop++;
        if (bus.rx_err) n_err++;
        if (bus.rx_active) n_act++;
        if (bus.rx_valid) begin
            if (n_valid < 256) got[n_valid] = bus.rx_data;
            n_valid++;
        end
        if ((bus.rx_valid && bus.rx_eop) || (bus.rx_err && bus.rx_eop)) overlap_seen++;
    end

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", name, actual, expected);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " line_state"}, int'(bus.line_state), 0);
        check({tag, " rx_active"}, int'(bus.rx_active), 0);
        check({tag, " rx_sop"}, int'(bus.rx_sop), 0);
        check({tag, " rx_data"}, int'(bus.rx_data), 0);
        check({tag, " rx_valid"}, int'(bus.rx_valid), 0);
        check({tag, " rx_eop"}, int'(bus.rx_eop), 0);
        check({tag, " rx_err"}, int'(bus.rx_err), 0);
        check({tag, " usb_reset"}, int'(bus.usb_reset), 0);
    endtask

    task automatic drive(input logic [1:0] lvl, input int cycles);
        bus.usb_d_p = lvl[1];
        bus.usb_d_n = lvl[0];
        repeat (cycles) @(negedge clk48);
    endtask

    function automatic int period(input int mode, input int k);
        if (mode == 1 && (k % 4) == 3) return 5;
        if (mode == 2 && (k % 4) == 3) return 3;
        return 4;
    endfunction

    function automatic logic [1:0] flip(input logic [1:0] lvl);
        return (lvl == J) ? K : J;
    endfunction

    // 12 idle J bits, 8 SYNC bits, stuffed NRZI data, SE0 x2, 4 J bits.
    task automatic send_packet(input logic [7:0] sync, input logic [31:0] data, input int nbits,
                               input int omit, input int mode, input int rst_bit);
        logic [1:0] lv[$];
        logic [1:0] cur;
        int ones;
        int nstuff;
        lv = {};
        for (int i = 0; i < 12; i++) lv.push_back(J);
        cur = J;
        for (int i = 0; i < 8; i++) begin
            if (!sync[i]) cur = flip(cur);
            lv.push_back(cur);
        end
        ones = 0;
        nstuff = 0;
        for (int i = 0; i < nbits; i++) begin
            if (!data[i]) begin
                cur = flip(cur);
                ones = 0;
            end else begin
                ones++;
            end
            lv.push_back(cur);
            if (ones == 6) begin
                nstuff++;
                ones = 0;
                if (nstuff != omit) begin
                    cur = flip(cur);
                    lv.push_back(cur);
                end
            end
        end
        lv.push_back(SE0);
        lv.push_back(SE0);
        for (int i = 0; i < 4; i++) lv.push_back(J);
        for (int i = 0; i < lv.size(); i++) begin
            if (i == rst_bit) begin
                bus.usb_d_p = lv[i][1];
                bus.usb_d_n = lv[i][0];
                rst = 1'b1;
                @(negedge clk48);
                rst = 1'b0;
                valid_at_rst = n_valid;
                check_all_zero("midrst");
                repeat (period(mode, i) - 1) @(negedge clk48);
            end else begin
                drive(lv[i], period(mode, i));
            end
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int s_sop;
        int s_valid;
        int s_eop;
        int s_err;
        int s_act;
        s_sop = n_sop;
        s_valid = n_valid;
        s_eop = n_eop;
        s_err = n_err;
        s_act = n_act;
        send_packet(v.sync, v.data, v.nbits, v.omit, v.mode, -1);
        check($sformatf("v%0d sop", idx), n_sop - s_sop, v.exp_sop);
        check($sformatf("v%0d nvalid", idx), n_valid - s_valid, v.exp_nvalid);
        for (int j = 0; j < v.exp_nvalid && j < 4 && (s_valid + j) < n_valid && (s_valid + j) < 256; j++)
            check($sformatf("v%0d byte%0d", idx, j), int'(got[s_valid + j]), int'(v.exp_bytes[8*j +: 8]));
        check($sformatf("v%0d eop", idx), n_eop - s_eop, v.exp_eop);
        check($sformatf("v%0d err", idx), n_err - s_err, v.exp_err);
        check($sformatf("v%0d active_seen", idx), int'((n_act - s_act) > 0), v.exp_sop);
        check($sformatf("v%0d active_after", idx), int'(bus.rx_active), 0);
    endtask

    initial begin
        int s_sop;
        int s_valid;
        int s_eop;
        int s_err;
        vecs[0] = '{8'h80, 32'h0010002D, 24, 0, 0, 1, 3, 32'h0010002D, 1, 0};
        vecs[1] = '{8'h80, 32'h0010002D, 24, 0, 1, 1, 3, 32'h0010002D, 1, 0};
        vecs[2] = '{8'h80, 32'h0010002D, 24, 0, 2, 1, 3, 32'h0010002D, 1, 0};
        vecs[3] = '{8'h80, 32'h0000FFFF, 16, 0, 0, 1, 2, 32'h0000FFFF, 1, 0};
        vecs[4] = '{8'h80, 32'h0000FFFF, 16, 1, 0, 1, 0, 32'h00000000, 0, 1};
        vecs[5] = '{8'h80, 32'h000003A5, 12, 0, 0, 1, 1, 32'h000000A5, 0, 1};
        vecs[6] = '{8'h80, 32'hC37E0180, 32, 0, 0, 1, 4, 32'hC37E0180, 1, 0};
        vecs[7] = '{8'h88, 32'h0010002D, 24, 0, 0, 0, 0, 32'h00000000, 0, 1};

        rst = 1'b1;
        bus.usb_d_p = 1'b1;
        bus.usb_d_n = 1'b0;
        repeat (3) @(negedge clk48);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk48);
        check("ls 1 cycle after rst", int'(bus.line_state), int'(SE0));
        @(negedge clk48);
        check("ls 2 cycles after rst", int'(bus.line_state), int'(J));
        repeat (8) @(negedge clk48);

        // Bus reset: SE0 for 200 cycles, then J.
        s_sop = n_sop;
        s_valid = n_valid;
        s_eop = n_eop;
        s_err = n_err;
        drive(SE0, 121);
        check("usb_reset cycle 121", int'(bus.usb_reset), 0);
        drive(SE0, 1);
        check("usb_reset cycle 122", int'(bus.usb_reset), 1);
        drive(SE0, 78);
        check("usb_reset cycle 200", int'(bus.usb_reset), 1);
        drive(J, 2);
        check("usb_reset J+2", int'(bus.usb_reset), 1);
        drive(J, 1);
        check("usb_reset J+3", int'(bus.usb_reset), 0);
        drive(J, 40);
        check("busrst sop", n_sop - s_sop, 0);
        check("busrst valid", n_valid - s_valid, 0);
        check("busrst eop", n_eop - s_eop, 0);
        check("busrst err", n_err - s_err, 0);

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // One-cycle rst in the middle of the second byte.
        s_sop = n_sop;
        s_valid = n_valid;
        s_eop = n_eop;
        s_err = n_err;
        valid_at_rst = -1;
        send_packet(8'h80, 32'h0010002D, 24, 0, 0, 32);
        check("midrst sop", n_sop - s_sop, 1);
        check("midrst valid before", valid_at_rst - s_valid, 1);
        check("midrst valid after", n_valid - valid_at_rst, 0);
        check("midrst eop", n_eop - s_eop, 0);
        check("midrst err", n_err - s_err, 0);
        run_vec(vecs[0], 8);

        check("valid/err with eop overlap", overlap_seen, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
